// File: rtl/riscv_instr_port_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_instr_port_arbiter
//
// Shares one instruction-memory port (req/gnt/rvalid protocol) between two
// requesters: requester 0 is the IF-stage prefetch buffer and requester 1 is
// the debug unit's instruction fetch path. Arbitration is round-robin. A
// request that has been presented but not yet granted is locked to its
// requester until it is granted or withdrawn. Each accepted transaction
// pushes its requester ID into a small FIFO so that every response is routed
// back to the requester that issued it. The grant and response paths are
// purely combinational, so the block adds no cycles.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   m0_req_i/m0_addr_i              requester 0 request and address
//   m0_gnt_o/m0_rvalid_o            requester 0 grant and response valid
//   m1_req_i/m1_addr_i              requester 1 request and address
//   m1_gnt_o/m1_rvalid_o            requester 1 grant and response valid
//   rdata_o                         response data shared by both requesters
//   mem_req_o/mem_addr_o            request toward instruction memory
//   mem_gnt_i                       memory grant
//   mem_rvalid_i/mem_rdata_i        memory response
//   busy_o                          transaction outstanding or request pending
//   err_o                           sticky: response arrived with nothing outstanding
// -----------------------------------------------------------------------------
module riscv_instr_port_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int RDATA_WIDTH     = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   m0_req_i,
    input  logic [ADDR_WIDTH-1:0]  m0_addr_i,
    output logic                   m0_gnt_o,
    output logic                   m0_rvalid_o,

    input  logic                   m1_req_i,
    input  logic [ADDR_WIDTH-1:0]  m1_addr_i,
    output logic                   m1_gnt_o,
    output logic                   m1_rvalid_o,

    output logic [RDATA_WIDTH-1:0] rdata_o,

    output logic                   mem_req_o,
    output logic [ADDR_WIDTH-1:0]  mem_addr_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [RDATA_WIDTH-1:0] mem_rdata_i,

    output logic                   busy_o,
    output logic                   err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

    // Arbitration state
    logic prio_reg, prio_next;
    logic lock_reg, lock_next;
    logic lock_id_reg, lock_id_next;

    // ID FIFO state
    logic [MAX_OUTSTANDING-1:0] id_reg, id_next;
    logic [PTR_W-1:0]           wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]           rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]           count_reg, count_next;

    logic err_reg, err_next;

    // Combinational datapath
    logic sel;
    logic sel_req;
    logic full_block;
    logic mem_req;
    logic handshake;
    logic push;
    logic pop;
    logic head;

    // Winner selection: a pending (locked) request keeps the port until it is
    // granted or withdrawn, so the address seen by memory stays stable.
    always_comb begin
        sel = 1'b0;
        if (lock_reg) begin
            sel = lock_id_reg;
        end else if (m0_req_i && m1_req_i) begin
            sel = prio_reg;
        end else if (m1_req_i) begin
            sel = 1'b1;
        end
    end

    assign sel_req = sel ? m1_req_i : m0_req_i;

    // A response arriving this cycle frees a slot that can be reused at once.
    assign full_block = (count_reg == CNT_MAX) && !mem_rvalid_i;
    assign mem_req    = rst_n && sel_req && !full_block;
    assign handshake  = mem_req && mem_gnt_i;
    assign push       = handshake;
    assign pop        = mem_rvalid_i && (count_reg != '0);
    assign head       = id_reg[rd_ptr_reg];

    // Request path
    assign mem_req_o  = mem_req;
    assign mem_addr_o = sel ? m1_addr_i : m0_addr_i;
    assign m0_gnt_o   = handshake && !sel;
    assign m1_gnt_o   = handshake && sel;

    // Response path; pop already excludes spurious responses.
    assign rdata_o     = mem_rdata_i;
    assign m0_rvalid_o = rst_n && pop && !head;
    assign m1_rvalid_o = rst_n && pop && head;

    assign busy_o = (count_reg != '0) || mem_req;
    assign err_o  = err_reg;

    // ID FIFO storage: each entry is written only when the write pointer
    // addresses it during a handshake.
    generate
        for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_id
            assign id_next[gi] = (push && (wr_ptr_reg == PTR_W'(gi))) ? sel : id_reg[gi];
        end
    endgenerate

    always_comb begin
        prio_next    = prio_reg;
        lock_next    = lock_reg;
        lock_id_next = lock_id_reg;
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        count_next   = count_reg;
        err_next     = err_reg;

        if (handshake) begin
            lock_next = 1'b0;
            prio_next = ~sel;
        end else if (mem_req) begin
            lock_next    = 1'b1;
            lock_id_next = sel;
        end else if (lock_reg && !sel_req) begin
            // Locked requester withdrew (e.g. prefetch flushed on a branch).
            lock_next = 1'b0;
        end

        if (push) begin
            wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (pop) begin
            rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
        end

        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!push && pop) begin
            count_next = count_reg - 1'b1;
        end

        if (mem_rvalid_i && (count_reg == '0)) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_reg    <= 1'b0;
            lock_reg    <= 1'b0;
            lock_id_reg <= 1'b0;
            id_reg      <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            err_reg     <= 1'b0;
        end else begin
            prio_reg    <= prio_next;
            lock_reg    <= lock_next;
            lock_id_reg <= lock_id_next;
            id_reg      <= id_next;
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            count_reg   <= count_next;
            err_reg     <= err_next;
        end
    end

endmodule

// File: tb/tb_riscv_instr_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_riscv_instr_port_arbiter
//
// Directed bench for riscv_instr_port_arbiter. The bench plays the memory:
// it answers accepted addresses in order with data derived from the address.
// Every expected handshake pushes {requester, data} into a scoreboard queue;
// every response the bench drives pops it and checks routing and data.
// -----------------------------------------------------------------------------
module tb_riscv_instr_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req_i;
    logic [31:0] m0_addr_i;
    logic        m0_gnt_o;
    logic        m0_rvalid_o;
    logic        m1_req_i;
    logic [31:0] m1_addr_i;
    logic        m1_gnt_o;
    logic        m1_rvalid_o;
    logic [31:0] rdata_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;
    logic        err_o;

    riscv_instr_port_arbiter #(
        .ADDR_WIDTH      (32),
        .RDATA_WIDTH     (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m0_req_i     (m0_req_i),
        .m0_addr_i    (m0_addr_i),
        .m0_gnt_o     (m0_gnt_o),
        .m0_rvalid_o  (m0_rvalid_o),
        .m1_req_i     (m1_req_i),
        .m1_addr_i    (m1_addr_i),
        .m1_gnt_o     (m1_gnt_o),
        .m1_rvalid_o  (m1_rvalid_o),
        .rdata_o      (rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        id;
        logic [31:0] data;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] mem_q[$];

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] addr);
        return addr ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive inputs, check combinational outputs at the falling
    // edge, record the expected handshake, then advance past the rising edge.
    task automatic cyc(input string tag,
                       input logic m0r, input logic [31:0] m0a,
                       input logic m1r, input logic [31:0] m1a,
                       input logic gnt, input logic rv,
                       input logic exp_req, input logic exp_sel);
        sb_t e;
        m0_req_i     = m0r;
        m0_addr_i    = m0a;
        m1_req_i     = m1r;
        m1_addr_i    = m1a;
        mem_gnt_i    = gnt;
        mem_rvalid_i = rv;
        if (rv && mem_q.size() > 0) mem_rdata_i = mem_data(mem_q.pop_front());
        else                        mem_rdata_i = 32'hDEAD_BEEF;

        @(negedge clk);
        chk({tag, " mem_req"}, {31'd0, mem_req_o}, {31'd0, exp_req});
        if (exp_req) chk({tag, " mem_addr"}, mem_addr_o, exp_sel ? m1a : m0a);
        chk({tag, " m0_gnt"}, {31'd0, m0_gnt_o}, {31'd0, exp_req && gnt && !exp_sel});
        chk({tag, " m1_gnt"}, {31'd0, m1_gnt_o}, {31'd0, exp_req && gnt && exp_sel});

        if (rv && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, " m0_rvalid"}, {31'd0, m0_rvalid_o}, {31'd0, !e.id});
            chk({tag, " m1_rvalid"}, {31'd0, m1_rvalid_o}, {31'd0, e.id});
            chk({tag, " rdata"}, rdata_o, e.data);
            $display("%s: response to m%0d data=%08h", tag, e.id, rdata_o);
        end else begin
            chk({tag, " m0_rvalid idle"}, {31'd0, m0_rvalid_o}, 32'd0);
            chk({tag, " m1_rvalid idle"}, {31'd0, m1_rvalid_o}, 32'd0);
        end

        if (exp_req && gnt) begin
            sb_q.push_back({exp_sel, mem_data(exp_sel ? m1a : m0a)});
            mem_q.push_back(mem_addr_o);
            $display("%s: grant to m%0d addr=%08h", tag, exp_sel, mem_addr_o);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n        = 1'b0;
        m0_req_i     = 1'b0;
        m0_addr_i    = '0;
        m1_req_i     = 1'b0;
        m1_addr_i    = '0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        @(posedge clk);
        #1;

        // Reset: requests and grant present but outputs forced low
        cyc("rst", 1, 32'h100, 1, 32'h200, 1, 0, 0, 0);
        chk("rst busy", {31'd0, busy_o}, 32'd0);
        chk("rst err", {31'd0, err_o}, 32'd0);
        rst_n = 1'b1;

        // Single requester, back-to-back, response one cycle later
        cyc("single0", 1, 32'h100, 0, 32'h0, 1, 0, 1, 0);
        cyc("single1", 1, 32'h104, 0, 32'h0, 1, 1, 1, 0);
        cyc("single2", 1, 32'h108, 0, 32'h0, 1, 1, 1, 0);
        cyc("single3", 0, 32'h0,   0, 32'h0, 1, 1, 0, 0);
        chk("single idle busy", {31'd0, busy_o}, 32'd0);
        chk("single err", {31'd0, err_o}, 32'd0);

        // Spurious response: no routing, sticky error
        cyc("spur", 0, 32'h0, 0, 32'h0, 0, 1, 0, 0);
        chk("spur err set", {31'd0, err_o}, 32'd1);
        cyc("spur_idle", 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
        chk("spur err sticky", {31'd0, err_o}, 32'd1);

        // Reset clears the error
        rst_n = 1'b0;
        cyc("rst2", 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
        rst_n = 1'b1;
        chk("rst2 err", {31'd0, err_o}, 32'd0);

        // Contention straight after reset: strict alternation starting at m0
        cyc("cont0", 1, 32'h200, 1, 32'h300, 1, 0, 1, 0);
        cyc("cont1", 1, 32'h200, 1, 32'h300, 1, 1, 1, 1);
        cyc("cont2", 1, 32'h204, 1, 32'h300, 1, 1, 1, 0);
        cyc("cont3", 1, 32'h208, 1, 32'h304, 1, 1, 1, 1);
        cyc("cont4", 0, 32'h0,   0, 32'h0,   1, 1, 0, 0);

        // Full FIFO: two grants, then blocked until a response frees a slot
        cyc("full0", 1, 32'h400, 0, 32'h0, 1, 0, 1, 0);
        cyc("full1", 1, 32'h404, 0, 32'h0, 1, 0, 1, 0);
        cyc("full2", 1, 32'h408, 0, 32'h0, 1, 0, 0, 0);
        chk("full busy", {31'd0, busy_o}, 32'd1);
        cyc("full3", 1, 32'h408, 0, 32'h0, 1, 0, 0, 0);
        cyc("full4", 1, 32'h408, 0, 32'h0, 1, 1, 1, 0);
        cyc("full5", 1, 32'h40C, 0, 32'h0, 1, 0, 0, 0);
        cyc("full6", 0, 32'h0,   0, 32'h0, 0, 1, 0, 0);
        cyc("full7", 0, 32'h0,   0, 32'h0, 0, 1, 0, 0);

        // Grant m1 once so m0 holds priority during the lock test
        cyc("pre0", 0, 32'h0, 1, 32'h480, 1, 0, 1, 1);
        cyc("pre1", 0, 32'h0, 0, 32'h0,   0, 1, 0, 0);

        // Lock and withdraw: m1 keeps the port until it drops its request
        cyc("lock0", 0, 32'h0,   1, 32'h500, 0, 0, 1, 1);
        cyc("lock1", 1, 32'h600, 1, 32'h500, 0, 0, 1, 1);
        cyc("lock2", 1, 32'h600, 1, 32'h500, 0, 0, 1, 1);
        cyc("lock3", 1, 32'h600, 0, 32'h500, 0, 0, 0, 0);
        cyc("lock4", 1, 32'h600, 0, 32'h0,   0, 0, 1, 0);
        cyc("lock5", 1, 32'h600, 0, 32'h0,   1, 0, 1, 0);
        cyc("lock6", 0, 32'h0,   0, 32'h0,   0, 1, 0, 0);

        // Mid-transaction reset with two outstanding (m1 then m0, prio -> 1)
        cyc("mid0", 0, 32'h0,   1, 32'h800, 1, 0, 1, 1);
        cyc("mid1", 1, 32'h700, 0, 32'h0,   1, 0, 1, 0);
        rst_n = 1'b0;
        cyc("midrst", 0, 32'h0, 0, 32'h0, 0, 0, 0, 0);
        rst_n = 1'b1;
        sb_q.delete();
        chk("mid busy", {31'd0, busy_o}, 32'd0);
        chk("mid err", {31'd0, err_o}, 32'd0);
        // Priority back to m0 after reset
        cyc("mid_prio", 1, 32'h900, 1, 32'hA00, 0, 0, 1, 0);
        // Stale response from before reset is spurious
        cyc("mid_stale", 0, 32'h0, 0, 32'h0, 0, 1, 0, 0);
        chk("mid stale err", {31'd0, err_o}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_instr_port_arbiter.md
# riscv_instr_port_arbiter

Shares the single core instruction-memory port between two requesters that use the core's req/gnt/rvalid protocol. Requester 0 is the IF-stage prefetch buffer; requester 1 is the debug unit's instruction-memory access path. The block does round-robin arbitration, holds a pending request stable until it is granted, and tracks outstanding transactions in an ID FIFO so every rvalid/rdata goes back to the requester that issued it. It sits between the IF stage and the instruction memory/cache, and adds no cycles to the grant or response path.

## Interface
- ADDR_WIDTH, 32, address width on all ports
- RDATA_WIDTH, 32, read-data width on all ports
- MAX_OUTSTANDING, 2, maximum accepted-but-unanswered memory transactions (1..4); sets the depth of the ID FIFO

- clk  in  1  single clock; all state updates on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- m0_req_i  in  1  requester 0 (IF prefetch) request
- m0_addr_i  in  ADDR_WIDTH  requester 0 address
- m0_gnt_o  out  1  requester 0 grant
- m0_rvalid_o  out  1  requester 0 response valid
- m1_req_i, m1_addr_i, m1_gnt_o, m1_rvalid_o  same directions and widths as above, for requester 1 (debug)
- rdata_o  out  RDATA_WIDTH  response data, shared by both requesters; qualified by the per-requester rvalid
- mem_req_o  out  1  memory request
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_gnt_i  in  1  memory grant
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  RDATA_WIDTH  memory response data
- busy_o  out  1  high when any transaction is outstanding or a request is pending
- err_o  out  1  sticky error flag; set by an rvalid that arrives with the FIFO empty

## Operation
- **Arbitration.**
  - State: pointer `prio` (which requester wins on contention), `lock` (a request is pending), `lock_id`.
  - With `lock` clear:
    - If both requesters are requesting, `prio` wins.
    - Otherwise the single requester wins.
    - The winner becomes `sel`.
  - With `lock` set: `sel = lock_id`, regardless of other requests.
- **Request path.**
  - mem_req_o = req of `sel` AND NOT `full_block`.
  - mem_addr_o = addr of `sel`.
  - m{sel}_gnt_o = mem_gnt_i AND mem_req_o.
  - The non-selected grant is 0.
- **Lock.**
  - Set when mem_req_o=1 and mem_gnt_i=0; `lock_id` is loaded with `sel`.
  - Cleared on the handshake (mem_req_o AND mem_gnt_i).
  - Also cleared if the locked requester drops its req. The IF prefetch may withdraw a request on a branch; this is legal.
- **Pointer.** On every handshake, `prio` is set to the requester that was not just granted.
- **ID FIFO.**
  - Circular buffer of MAX_OUTSTANDING 1-bit entries, with a count of width clog2(MAX_OUTSTANDING+1).
  - Push `sel` on a handshake; pop on mem_rvalid_i.
  - A simultaneous push and pop leaves the count unchanged, and both pointers advance.
  - `full_block` = (count == MAX_OUTSTANDING) AND NOT mem_rvalid_i. A slot freed in the same cycle may therefore be reused.
- **Response routing.**
  - m{head}_rvalid_o = mem_rvalid_i when count>0.
  - rdata_o = mem_rdata_i, passed through combinationally.
  - mem_rvalid_i with count==0: no rvalid is driven, err_o is set, FIFO state is unchanged.
- **busy_o** = (count != 0) OR mem_req_o.
- **Reset** (rst_n low at a clock edge):
  - count=0, both FIFO pointers 0, prio=0 (requester 0 favoured), lock=0, err_o=0.
  - While rst_n is low, mem_req_o, both gnt outputs and both rvalid outputs are forced 0.
  - Reset in the middle of a transaction discards all outstanding IDs. Responses that arrive after reset are treated as spurious and set err_o.

## Timing
- Grant path is combinational: mem_gnt_i to m*_gnt_o in 0 cycles.
- Response path is combinational: mem_rvalid_i/mem_rdata_i to requester outputs in 0 cycles.
- Back-to-back handshakes are allowed every cycle while the FIFO is not full.
- Under continuous contention, grants alternate strictly 0,1,0,1,...
- A blocked request (FIFO full) issues in the same cycle the rvalid that frees a slot arrives.
- Responses return in issue order; the memory must never reorder.

## Test plan
- **Single requester:** m0 requests 0x100, 0x104, 0x108 with gnt always high and rvalid one cycle later. Required: three m0_gnt pulses in consecutive cycles; three m0_rvalid pulses carrying the matching data; m1_rvalid stays 0.
- **Contention:** m0 and m1 both request continuously after reset. Required: grant order m0,m1,m0,m1; each rvalid routed to the matching requester per FIFO order.
- **Full FIFO (MAX_OUTSTANDING=2):** two grants, rvalid withheld. Required: mem_req_o=0 while m0_req_i=1. When rvalid arrives in cycle N, mem_req_o=1 and the handshake completes in cycle N; count stays 2.
- **Lock and withdraw:** m1 requests with gnt low for 3 cycles while m0 raises req. Required: mem_addr_o holds m1's address. Then m1 drops req; in the next cycle m0 is selected and mem_addr_o switches to m0's address.
- **Spurious rvalid:** rvalid with nothing outstanding. Required: no requester rvalid, err_o=1 and stays 1 until reset.
- **Mid-transaction reset:** assert rst_n=0 for 1 cycle with 2 outstanding. Required: count=0, busy_o=0, prio=0; a later rvalid sets err_o.
